// File: rtl/mod_playback_ctrl.sv
// Playback sequencer for the double-buffered modulation BRAM: tick divider, wrapping index,
// SYNC alignment after an init request, and page swaps deferred to cycle boundaries.
module mod_playback_ctrl #(
   parameter int IDX_W = 16,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ref_clk_tick,
   input  logic [IDX_W-1:0] cycle,
   input  logic [DIV_W-1:0] div,
   input  logic             init_req,
   input  logic             sync,
   input  logic [IDX_W-1:0] init_idx,
   input  logic [DIV_W-1:0] init_div,
   input  logic             page_req,
   input  logic             page_sel,
   output logic             page_ack,
   output logic             active_page,
   output logic [IDX_W-1:0] mod_idx,
   output logic [IDX_W:0]   mod_addr,
   output logic             wrap,
   output logic             running
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             page_q, page_d;
   logic             ack_q, ack_d;
   logic             wrap_q, wrap_d;
   logic             running_q, running_d;
   logic             pend_q, pend_d;
   logic             pend_sel_q, pend_sel_d;
   logic             init_req_q, init_req_d;

   logic             init_rise;
   logic             load_sync;
   logic             adv_wrap;
   logic             apply_ok;
   logic             same_page_req;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      div_d      = div_q;
      load_sync  = 1'b0;
      adv_wrap   = 1'b0;
      init_req_d = init_req;
      init_rise  = init_req & ~init_req_q;

      case (state_q)
         S_IDLE: begin
            idx_d = '0;
            div_d = '0;
            if (init_rise) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (sync) begin
               idx_d     = init_idx;
               div_d     = init_div;
               load_sync = 1'b1;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (init_rise) state_d = S_ARMED;
         end
         default: state_d = S_IDLE;
      endcase

      // >= rather than == so that shrinking cycle/div on the fly still wraps promptly
      if (state_q != S_IDLE && !load_sync && ref_clk_tick) begin
         if (div_q >= div) begin
            div_d = '0;
            if (idx_q >= cycle) begin
               idx_d    = '0;
               adv_wrap = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end else begin
            div_d = div_q + DIV_W'(1);
         end
      end

      wrap_d    = adv_wrap;
      running_d = (state_d == S_RUN);
   end

   always_comb begin
      pend_d        = pend_q;
      pend_sel_d    = pend_sel_q;
      page_d        = page_q;
      ack_d         = 1'b0;
      same_page_req = page_req & ~pend_q & (page_sel == page_q);
      // While playing, a swap may only land together with the index returning to 0;
      // a pending swap across a SYNC load waits for the first wrap of the new run.
      apply_ok      = (state_q == S_RUN) ? adv_wrap : ~load_sync;

      if (same_page_req) begin
         ack_d = 1'b1;
      end else begin
         if (page_req) begin
            pend_d     = 1'b1;
            pend_sel_d = page_sel;
         end
         if (pend_d && apply_ok) begin
            page_d = pend_sel_d;
            ack_d  = 1'b1;
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         div_q      <= '0;
         page_q     <= 1'b0;
         ack_q      <= 1'b0;
         wrap_q     <= 1'b0;
         running_q  <= 1'b0;
         pend_q     <= 1'b0;
         pend_sel_q <= 1'b0;
         init_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         div_q      <= div_d;
         page_q     <= page_d;
         ack_q      <= ack_d;
         wrap_q     <= wrap_d;
         running_q  <= running_d;
         pend_q     <= pend_d;
         pend_sel_q <= pend_sel_d;
         init_req_q <= init_req_d;
      end
   end

   assign page_ack    = ack_q;
   assign active_page = page_q;
   assign mod_idx     = idx_q;
   assign mod_addr    = {page_q, idx_q};
   assign wrap        = wrap_q;
   assign running     = running_q;

endmodule
